// File: rtl/sliding_tile_nxn_if.sv
// Port bundle between the sliding-tile engine and its input decoder / display consumers.
// The master drives moves, loads and shuffles; the slave (engine) returns board and status.
interface sliding_tile_nxn_if #(
   parameter int unsigned N  = 3,
   parameter int unsigned TW = 4,
   parameter int unsigned CW = 16
);
   logic                  move_val;
   logic [1:0]            direction;
   logic                  load;
   logic [N*N*TW-1:0]     load_board;
   logic                  shuffle_start;
   logic [15:0]           seed;
   logic [N*N*TW-1:0]     board;
   logic [1:0]            space_row;
   logic [1:0]            space_col;
   logic                  ready;
   logic                  solved;
   logic                  illegal;
   logic [CW-1:0]         move_count;

   modport master (
      output move_val, direction, load, load_board, shuffle_start, seed,
      input  board, space_row, space_col, ready, solved, illegal, move_count
   );

   modport slave (
      input  move_val, direction, load, load_board, shuffle_start, seed,
      output board, space_row, space_col, ready, solved, illegal, move_count
   );
endinterface

// File: rtl/sliding_tile_nxn.sv
// N x N sliding-tile puzzle engine: player moves, board load, LFSR shuffle,
// saturating move counter and illegal-move pulse.
module sliding_tile_nxn #(
   parameter int unsigned N          = 3,
   parameter int unsigned TW         = 4,
   parameter int unsigned CW         = 16,
   parameter int unsigned SHUF_MOVES = 32
) (
   input logic               clk,
   input logic               reset,
   sliding_tile_nxn_if.slave bus
);
   localparam int unsigned CELLS = N * N;
   localparam int unsigned IW    = $clog2(CELLS);
   localparam int unsigned RW    = $clog2(SHUF_MOVES + 1);

   typedef enum logic {StPlay, StShuffle} state_e;

   state_e          state_q, state_d;
   logic [TW-1:0]   cells_q [CELLS];
   logic [TW-1:0]   cells_d [CELLS];
   logic [TW-1:0]   load_cells [CELLS];
   logic [TW-1:0]   swap_cells [CELLS];
   logic [1:0]      row_q, row_d, col_q, col_d;
   logic [15:0]     lfsr_q, lfsr_d, lfsr_next;
   logic [RW-1:0]   remaining_q, remaining_d;
   logic [CW-1:0]   count_q, count_d;
   logic            illegal_q, illegal_d;

   logic            zero_found;
   logic [1:0]      zero_row, zero_col;
   logic [1:0]      move_dir, nb_row, nb_col;
   logic            move_legal;
   logic [IW-1:0]   space_idx, nb_idx;
   logic [N*N*TW-1:0] board_flat;
   logic            solved_c;

   // Unpack the load bus and find the lowest-index zero (descending scan, last hit wins).
   always_comb begin
      zero_found = 1'b0;
      zero_row   = '0;
      zero_col   = '0;
      for (int i = 0; i < int'(CELLS); i++) begin
         load_cells[i] = bus.load_board[i*TW +: TW];
      end
      for (int r = int'(N) - 1; r >= 0; r--) begin
         for (int c = int'(N) - 1; c >= 0; c--) begin
            if (load_cells[r*int'(N) + c] == '0) begin
               zero_found = 1'b1;
               zero_row   = 2'(r);
               zero_col   = 2'(c);
            end
         end
      end
   end

   // Direction comes from the player in PLAY and from the LFSR during a shuffle.
   always_comb begin
      move_dir   = (state_q == StShuffle) ? lfsr_q[1:0] : bus.direction;
      nb_row     = row_q;
      nb_col     = col_q;
      move_legal = 1'b0;
      case (move_dir)
         2'b00: begin
            move_legal = (col_q != 2'd0);
            nb_col     = col_q - 2'd1;
         end
         2'b01: begin
            move_legal = (32'(col_q) < N - 1);
            nb_col     = col_q + 2'd1;
         end
         2'b10: begin
            move_legal = (row_q != 2'd0);
            nb_row     = row_q - 2'd1;
         end
         default: begin
            move_legal = (32'(row_q) < N - 1);
            nb_row     = row_q + 2'd1;
         end
      endcase
      space_idx = IW'(32'(row_q) * N + 32'(col_q));
      nb_idx    = IW'(32'(nb_row) * N + 32'(nb_col));
      swap_cells            = cells_q;
      swap_cells[space_idx] = cells_q[nb_idx];
      swap_cells[nb_idx]    = cells_q[space_idx];
   end

   always_comb begin
      state_d     = state_q;
      cells_d     = cells_q;
      row_d       = row_q;
      col_d       = col_q;
      lfsr_d      = lfsr_q;
      remaining_d = remaining_q;
      count_d     = count_q;
      illegal_d   = 1'b0;
      lfsr_next   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      case (state_q)
         StPlay: begin
            if (bus.load) begin
               if (zero_found) begin
                  cells_d = load_cells;
                  row_d   = zero_row;
                  col_d   = zero_col;
                  count_d = '0;
               end else begin
                  illegal_d = 1'b1;
               end
            end else if (bus.shuffle_start) begin
               lfsr_d      = (bus.seed == 16'h0000) ? 16'h0001 : bus.seed;
               remaining_d = RW'(SHUF_MOVES);
               state_d     = StShuffle;
            end else if (bus.move_val) begin
               if (move_legal) begin
                  cells_d = swap_cells;
                  row_d   = nb_row;
                  col_d   = nb_col;
                  if (count_q != '1) count_d = count_q + CW'(1);
               end else begin
                  illegal_d = 1'b1;
               end
            end
         end
         StShuffle: begin
            lfsr_d = lfsr_next;
            if (move_legal) begin
               cells_d     = swap_cells;
               row_d       = nb_row;
               col_d       = nb_col;
               remaining_d = remaining_q - RW'(1);
               if (remaining_q == RW'(1)) begin
                  state_d = StPlay;
                  count_d = '0;
               end
            end
         end
         default: state_d = StPlay;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StPlay;
         for (int i = 0; i < int'(CELLS); i++) begin
            cells_q[i] <= (i == int'(CELLS) - 1) ? '0 : TW'(i + 1);
         end
         row_q       <= 2'(N - 1);
         col_q       <= 2'(N - 1);
         lfsr_q      <= 16'h0001;
         remaining_q <= '0;
         count_q     <= '0;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cells_q     <= cells_d;
         row_q       <= row_d;
         col_q       <= col_d;
         lfsr_q      <= lfsr_d;
         remaining_q <= remaining_d;
         count_q     <= count_d;
         illegal_q   <= illegal_d;
      end
   end

   always_comb begin
      solved_c = 1'b1;
      for (int i = 0; i < int'(CELLS); i++) begin
         board_flat[i*TW +: TW] = cells_q[i];
         if (cells_q[i] != ((i == int'(CELLS) - 1) ? TW'(0) : TW'(i + 1))) solved_c = 1'b0;
      end
   end

   assign bus.board      = board_flat;
   assign bus.space_row  = row_q;
   assign bus.space_col  = col_q;
   assign bus.ready      = (state_q == StPlay);
   assign bus.solved     = solved_c;
   assign bus.illegal    = illegal_q;
   assign bus.move_count = count_q;
endmodule
